// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_port_arbiter                                            |
// | Description : Shares one external SRAM between the fetch read port and the |
// |               data read/write port. Data wins arbitration; a multi-cycle   |
// |               sequencer drives registered SRAM strobes and returns data.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2  // cycles strobes are held, 1..15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_DONE,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  input  logic [3:0]  MEM_BE,
  output logic [31:0] MEM_RDATA,
  output logic        MEM_DONE,
  output logic        STALL_REQ,
  output logic [19:0] SRAM_ADDR,
  output logic [31:0] SRAM_DQ_O,
  output logic        SRAM_DQ_T,
  input  logic [31:0] SRAM_DQ_I,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [3:0]  SRAM_BE_N
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    WR_REC = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Counter value on the final strobe cycle of an access.
  localparam logic [3:0] c_last_cnt = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        own_mem_q, own_mem_d;   // 1 = data port owns the transaction
  logic [19:0] addr_q, addr_d;         // doubles as the registered SRAM_ADDR
  logic [31:0] wdata_q, wdata_d;       // doubles as the registered SRAM_DQ_O
  logic [3:0]  be_q, be_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        dq_t_q, dq_t_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        w_rd_last;
  logic        w_unused_addr_bits;

  // Address bits outside the 1M-word SRAM window and the byte offset are dropped.
  assign w_unused_addr_bits = ^{IF_ADDR[31:22], IF_ADDR[1:0], MEM_ADDR[31:22], MEM_ADDR[1:0]};

  // Final strobe cycle of a read: the pad data is sampled at the end of it.
  assign w_rd_last = ((state_q == IF_RD) || (state_q == MEM_RD)) && (cnt_q == c_last_cnt);

  // Arbitration and access sequencing; transaction fields are latched only in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_mem_d = own_mem_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    case (state_q)
      IDLE: begin
        if (MEM_REQ) begin
          own_mem_d = 1'b1;
          if (MEM_WE && (MEM_BE == 4'h0)) begin
            // Nothing to write: complete without touching the SRAM.
            state_d = DONE;
          end else begin
            addr_d  = MEM_ADDR[21:2];
            wdata_d = MEM_WDATA;
            be_d    = MEM_BE;
            cnt_d   = 4'd0;
            state_d = MEM_WE ? MEM_WR : MEM_RD;
          end
        end else if (IF_REQ) begin
          own_mem_d = 1'b0;
          addr_d    = IF_ADDR[21:2];
          cnt_d     = 4'd0;
          state_d   = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        if (cnt_q == c_last_cnt) state_d = DONE;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      MEM_WR: begin
        if (cnt_q == c_last_cnt) state_d = WR_REC;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      WR_REC:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe values for the coming cycle, decoded from the next state so pads are registered.
  always_comb begin
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    be_n_d     = 4'hF;
    dq_t_d     = 1'b0;
    if_done_d  = (state_d == DONE) && !own_mem_d;
    mem_done_d = (state_d == DONE) &&  own_mem_d;
    case (state_d)
      IF_RD, MEM_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      MEM_WR: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        be_n_d = ~be_d;
        dq_t_d = 1'b1;
      end
      WR_REC: begin
        // WE_N released while data and chip enable stay put for hold time.
        ce_n_d = 1'b0;
        be_n_d = ~be_d;
        dq_t_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, transaction fields, pad registers and read-data capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      own_mem_q   <= 1'b0;
      addr_q      <= 20'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'h0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      dq_t_q      <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_mem_q  <= own_mem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      dq_t_q     <= dq_t_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if (w_rd_last) begin
        if (own_mem_q) mem_rdata_q <= SRAM_DQ_I;
        else           if_rdata_q  <= SRAM_DQ_I;
      end
    end
  end

  assign IF_RDATA  = if_rdata_q;
  assign IF_DONE   = if_done_q;
  assign MEM_RDATA = mem_rdata_q;
  assign MEM_DONE  = mem_done_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ_O = wdata_q;
  assign SRAM_DQ_T = dq_t_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_BE_N = be_n_q;

  // Stall while any requester is waiting; drops in the completion cycle of the last one.
  assign STALL_REQ = (IF_REQ & ~if_done_q) | (MEM_REQ & ~mem_done_q);

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_port_arbiter                                         |
// | Description : Scoreboard bench for sram_port_arbiter. Three instances with |
// |               ACCESS_CYCLES 2, 1 and 15, each with its own SRAM model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_port_arbiter;

  logic CLK = 1'b0;
  logic RST;
  logic tb_init;
  always #5 CLK = ~CLK;

  logic [2:0]  if_req, if_done, mem_req, mem_we, mem_done, stall, dq_t, ce_n, oe_n, we_n;
  logic [31:0] if_addr [3];
  logic [31:0] if_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [31:0] dq_o [3];
  logic [31:0] dq_i [3];
  logic [3:0]  mem_be [3];
  logic [3:0]  be_n [3];
  logic [19:0] sram_addr [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned AC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    sram_port_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
      .CLK(CLK), .RST(RST),
      .IF_REQ(if_req[g]), .IF_ADDR(if_addr[g]), .IF_RDATA(if_rdata[g]), .IF_DONE(if_done[g]),
      .MEM_REQ(mem_req[g]), .MEM_WE(mem_we[g]), .MEM_ADDR(mem_addr[g]),
      .MEM_WDATA(mem_wdata[g]), .MEM_BE(mem_be[g]), .MEM_RDATA(mem_rdata[g]),
      .MEM_DONE(mem_done[g]), .STALL_REQ(stall[g]),
      .SRAM_ADDR(sram_addr[g]), .SRAM_DQ_O(dq_o[g]), .SRAM_DQ_T(dq_t[g]), .SRAM_DQ_I(dq_i[g]),
      .SRAM_CE_N(ce_n[g]), .SRAM_OE_N(oe_n[g]), .SRAM_WE_N(we_n[g]), .SRAM_BE_N(be_n[g])
    );
  end

  // SRAM models: 256 words each, byte-writable, asynchronous read when CE/OE low.
  logic [31:0] mem [3][256];
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int g = 0; g < 3; g++)
        for (int a = 0; a < 256; a++)
          mem[g][a] <= 32'h5A5A_0000 + 32'(a);
      mem[0][4]     <= 32'h2402_0005;
      mem[0][8'h40] <= 32'h1122_3344;
      mem[1][4]     <= 32'h1111_0001;
      mem[2][4]     <= 32'hFFFF_000F;
    end else begin
      for (int g = 0; g < 3; g++)
        if (!ce_n[g] && !we_n[g] && dq_t[g])
          for (int b = 0; b < 4; b++)
            if (!be_n[g][b]) mem[g][sram_addr[g][7:0]][8*b +: 8] <= dq_o[g][8*b +: 8];
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++)
      dq_i[g] = (!ce_n[g] && !oe_n[g]) ? mem[g][sram_addr[g][7:0]] : 32'hDEAD_BEEF;
  end

  typedef struct {
    int          inst;
    bit          is_mem;
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int contention = 0;
  int oe_low = 0, we_low = 0, ce_low = 0, stall_low = 0;
  logic [19:0] oe_addr = 20'h0;
  logic [3:0]  we_be_n = 4'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input bit m, input int c, input logic [31:0] d, input bit cd);
    exp_t e;
    e.inst = g; e.is_mem = m; e.cyc = c; e.data = d; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int g, input bit m, input logic [31:0] rd);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].inst == g && sb[i].is_mem == m) idx = i;
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done inst%0d %s at cycle %0d, expected no completion",
               g, m ? "mem" : "if", cyc);
    end else begin
      chk($sformatf("done_cycle_i%0d_%s", g, m ? "mem" : "if"), 64'(cyc), 64'(sb[idx].cyc));
      if (sb[idx].chk_data)
        chk($sformatf("rdata_i%0d_%s", g, m ? "mem" : "if"), 64'(rd), 64'(sb[idx].data));
      sb.delete(idx);
    end
  endtask

  // Cycle counter: value n during the cycle after the n-th rising edge.
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: completions against the scoreboard plus per-cycle strobe bookkeeping.
  initial forever begin
    @(negedge CLK);
    for (int g = 0; g < 3; g++) begin
      if (dq_t[g] === 1'b1 && oe_n[g] === 1'b0) contention++;
      if (if_done[g] === 1'b1)  sb_check(g, 1'b0, if_rdata[g]);
      if (mem_done[g] === 1'b1) sb_check(g, 1'b1, mem_rdata[g]);
    end
    if (oe_n[0] === 1'b0) begin oe_low++; oe_addr = sram_addr[0]; end
    if (we_n[0] === 1'b0) begin we_low++; we_be_n = be_n[0]; end
    if (ce_n[0] === 1'b0) ce_low++;
    if (stall[0] === 1'b0) stall_low++;
  end

  task automatic wait_done(input int g, input bit m);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge CLK);
      #1;
      seen = m ? mem_done[g] : if_done[g];
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout inst%0d %s: done not seen, required within 64 cycles",
               g, m ? "mem" : "if");
    end
    @(posedge CLK);
    #1;
    if (m) mem_req[g] = 1'b0;
    else   if_req[g]  = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin : stimulus
    int c0, s_oe, s_we, s_ce, s_st;
    RST = 1'b1;
    tb_init = 1'b1;
    if_req = '0; mem_req = '0; mem_we = '0;
    for (int g = 0; g < 3; g++) begin
      if_addr[g] = '0; mem_addr[g] = '0; mem_wdata[g] = '0; mem_be[g] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    tb_init = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_ce_n", 64'(ce_n[0]), 64'd1);
    chk("rst_oe_n", 64'(oe_n[0]), 64'd1);
    chk("rst_we_n", 64'(we_n[0]), 64'd1);
    chk("rst_be_n", 64'(be_n[0]), 64'hF);
    chk("rst_dq_t", 64'(dq_t[0]), 64'd0);
    chk("rst_addr", 64'(sram_addr[0]), 64'd0);
    chk("rst_dq_o", 64'(dq_o[0]), 64'd0);
    chk("rst_done", 64'({if_done[0], mem_done[0]}), 64'd0);
    chk("rst_rdata", {if_rdata[0], mem_rdata[0]}, 64'd0);
    chk("rst_stall", 64'(stall[0]), 64'd0);

    // Fetch read, ACCESS_CYCLES = 2
    @(posedge CLK); #1;
    c0 = cyc; s_oe = oe_low;
    if_addr[0] = 32'h8000_0010; if_req[0] = 1'b1;
    push(0, 1'b0, c0 + 3, 32'h2402_0005, 1'b1);
    wait_done(0, 1'b0);
    chk("fetch_oe_cycles", 64'(oe_low - s_oe), 64'd2);
    chk("fetch_sram_addr", 64'(oe_addr), 64'h00004);

    // Byte write to byte 3 of word 0x40
    @(posedge CLK); #1;
    c0 = cyc; s_we = we_low; s_ce = ce_low;
    mem_we[0] = 1'b1; mem_addr[0] = 32'h8000_0103; mem_be[0] = 4'b1000;
    mem_wdata[0] = 32'hAB00_0000; mem_req[0] = 1'b1;
    push(0, 1'b1, c0 + 4, 32'h0, 1'b0);
    wait_done(0, 1'b1);
    mem_we[0] = 1'b0;
    chk("wr_we_cycles", 64'(we_low - s_we), 64'd2);
    chk("wr_be_n", 64'(we_be_n), 64'b0111);
    chk("wr_ce_cycles", 64'(ce_low - s_ce), 64'd3);

    // Readback: only byte 3 changed
    @(posedge CLK); #1;
    c0 = cyc;
    mem_addr[0] = 32'h8000_0100; mem_req[0] = 1'b1;
    push(0, 1'b1, c0 + 3, 32'hAB22_3344, 1'b1);
    wait_done(0, 1'b1);

    // Contention: data read first, fetch four cycles later, stall held throughout
    @(posedge CLK); #1;
    c0 = cyc; s_st = stall_low;
    mem_addr[0] = 32'h8000_0100; if_addr[0] = 32'h8000_0010;
    mem_req[0] = 1'b1; if_req[0] = 1'b1;
    push(0, 1'b1, c0 + 3, 32'hAB22_3344, 1'b1);
    push(0, 1'b0, c0 + 7, 32'h2402_0005, 1'b1);
    wait_done(0, 1'b1);
    wait_done(0, 1'b0);
    // Only the final IF_DONE cycle may show STALL_REQ low.
    chk("contention_stall_low", 64'(stall_low - s_st), 64'd1);

    // Zero-BE write: immediate completion, no chip enable
    @(posedge CLK); #1;
    c0 = cyc; s_ce = ce_low;
    mem_we[0] = 1'b1; mem_be[0] = 4'h0; mem_addr[0] = 32'h8000_0200; mem_req[0] = 1'b1;
    push(0, 1'b1, c0 + 1, 32'h0, 1'b0);
    wait_done(0, 1'b1);
    chk("zbe_ce_cycles", 64'(ce_low - s_ce), 64'd0);

    // Reset in the middle of a write: aborted, no DONE
    @(posedge CLK); #1;
    mem_we[0] = 1'b1; mem_be[0] = 4'hF; mem_addr[0] = 32'h8000_0200;
    mem_wdata[0] = 32'hCAFE_F00D; mem_req[0] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_pre_we_n", 64'(we_n[0]), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1; mem_req[0] = 1'b0; mem_we[0] = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_ce_n", 64'(ce_n[0]), 64'd1);
    chk("abort_we_n", 64'(we_n[0]), 64'd1);
    chk("abort_dq_t", 64'(dq_t[0]), 64'd0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Clean start after abort
    @(posedge CLK); #1;
    c0 = cyc;
    if_addr[0] = 32'h8000_0010; if_req[0] = 1'b1;
    push(0, 1'b0, c0 + 3, 32'h2402_0005, 1'b1);
    wait_done(0, 1'b0);

    // ACCESS_CYCLES = 1: read latency 2, then a write with latency 3
    @(posedge CLK); #1;
    c0 = cyc;
    if_addr[1] = 32'h0000_0010; if_req[1] = 1'b1;
    push(1, 1'b0, c0 + 2, 32'h1111_0001, 1'b1);
    wait_done(1, 1'b0);
    @(posedge CLK); #1;
    c0 = cyc;
    mem_we[1] = 1'b1; mem_be[1] = 4'b0011; mem_addr[1] = 32'h0000_0010;
    mem_wdata[1] = 32'h0000_BEEF; mem_req[1] = 1'b1;
    push(1, 1'b1, c0 + 3, 32'h0, 1'b0);
    wait_done(1, 1'b1);
    mem_we[1] = 1'b0;
    @(posedge CLK); #1;
    c0 = cyc;
    mem_addr[1] = 32'h0000_0010; mem_req[1] = 1'b1;
    push(1, 1'b1, c0 + 2, 32'h1111_BEEF, 1'b1);
    wait_done(1, 1'b1);

    // ACCESS_CYCLES = 15: read latency 16
    @(posedge CLK); #1;
    c0 = cyc;
    mem_addr[2] = 32'h0000_0010; mem_req[2] = 1'b1;
    push(2, 1'b1, c0 + 16, 32'hFFFF_000F, 1'b1);
    wait_done(2, 1'b1);

    repeat (5) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("bus_contention_cycles", 64'(contention), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
